// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: shared FSM/channel encodings and helpers for the WS2812B frame streamer
package ws2812b_pkg;
  typedef enum logic [1:0] {IDLE, READ, EMIT} state_e;
  typedef enum logic [1:0] {CH_G, CH_R, CH_B} ch_e;
  localparam int BYTES_PER_LED = 3;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // bright + 1 makes 255 an exact identity and 0 a hard blank
  function automatic logic [7:0] scale(logic [7:0] c, logic [7:0] b);
    logic [15:0] p;
    p = {8'h00, c} * ({8'h00, b} + 16'd1);
    return p[15:8];
  endfunction
endpackage

// File: rtl/ws2812b_frame_streamer_if.sv
// ws2812b_frame_streamer_if: valid/ready byte stream from the streamer to the bit serializer
interface ws2812b_frame_streamer_if;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       byte_ready_i;
  logic       sof_o;
  logic       eof_o;
  modport master (output byte_o, byte_valid_o, sof_o, eof_o, input byte_ready_i);
  modport slave (input byte_o, byte_valid_o, sof_o, eof_o, output byte_ready_i);
endinterface

// File: rtl/ws2812b_pixel_ram.sv
// ws2812b_pixel_ram: double-buffered pixel store, write port on back buffer, 1-cycle read on front
module ws2812b_pixel_ram
  import ws2812b_pkg::*;
#(
  parameter int NUM_LED = 768,
  localparam int IDX_W = idx_w(NUM_LED)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             wr_buf_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [23:0]      wr_data_i,
  input  logic             re_i,
  input  logic             rd_buf_i,
  input  logic [IDX_W-1:0] rd_addr_i,
  output logic [23:0]      rd_data_o
);
  logic [23:0] mem [2][NUM_LED];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[wr_buf_i][wr_addr_i] <= wr_data_i;
    if (re_i) rd_data_o <= mem[rd_buf_i][rd_addr_i];
  end
endmodule

// File: rtl/ws2812b_frame_streamer.sv
// ws2812b_frame_streamer: launches frames from the front buffer as brightness-scaled G,R,B bytes
module ws2812b_frame_streamer
  import ws2812b_pkg::*;
#(
  parameter int NUM_LED = 768,
  parameter int FRAME_PERIOD = 3333334,
  localparam int IDX_W = idx_w(NUM_LED)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [IDX_W-1:0]         wr_addr_i,
  input  logic [23:0]              wr_rgb_i,
  input  logic                     swap_req_i,
  input  logic                     frame_req_i,
  input  logic [7:0]               bright_i,
  ws2812b_frame_streamer_if.master strm,
  output logic                     busy_o,
  output logic                     swap_done_o
);
  localparam int PW = FRAME_PERIOD > 1 ? $clog2(FRAME_PERIOD) : 1;
  state_e state;
  ch_e ch;
  logic [PW-1:0] per_cnt;
  logic [IDX_W-1:0] led_idx;
  logic [7:0] bright_q;
  logic [23:0] pix;
  logic front, launch_pend, swap_pend, tick, start, valid, sof, eof;
  logic [7:0] sel;
  assign tick = FRAME_PERIOD != 0 && per_cnt == PW'(FRAME_PERIOD - 1);
  assign start = state == IDLE && launch_pend;
  ws2812b_pixel_ram #(.NUM_LED(NUM_LED)) u_ram (
    .clk_i,
    .we_i(wr_en_i && 32'(wr_addr_i) < NUM_LED),
    .wr_buf_i(~front),
    .wr_addr_i,
    .wr_data_i(wr_rgb_i),
    .re_i(state == READ),
    .rd_buf_i(front),
    .rd_addr_i(led_idx),
    .rd_data_o(pix)
  );
  always_comb begin
    sel = ch == CH_G ? pix[15:8] : ch == CH_R ? pix[23:16] : pix[7:0];
    strm.byte_o = valid ? scale(sel, bright_q) : 8'h00;
  end
  assign strm.byte_valid_o = valid;
  assign strm.sof_o = sof;
  assign strm.eof_o = eof;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      ch <= CH_G;
      per_cnt <= '0;
      led_idx <= '0;
      bright_q <= '0;
      front <= 1'b0;
      launch_pend <= 1'b0;
      swap_pend <= 1'b0;
      valid <= 1'b0;
      sof <= 1'b0;
      eof <= 1'b0;
      busy_o <= 1'b0;
      swap_done_o <= 1'b0;
    end else begin
      per_cnt <= (tick || FRAME_PERIOD == 0) ? '0 : per_cnt + 1'b1;
      // a request landing on the start edge re-arms rather than being lost
      launch_pend <= tick || frame_req_i || (launch_pend && !start);
      swap_pend <= swap_req_i || (swap_pend && !start);
      swap_done_o <= start && swap_pend;
      unique case (state)
        IDLE: if (launch_pend) begin
          front <= front ^ swap_pend;
          bright_q <= bright_i;
          led_idx <= '0;
          ch <= CH_G;
          busy_o <= 1'b1;
          state <= READ;
        end
        READ: begin
          valid <= 1'b1;
          sof <= led_idx == '0;
          state <= EMIT;
        end
        EMIT: if (strm.byte_ready_i) begin
          if (ch != CH_B) begin
            ch <= ch_e'(ch + 2'd1);
            sof <= 1'b0;
            eof <= led_idx == IDX_W'(NUM_LED - 1) && ch == CH_R;
          end else if (eof) begin
            valid <= 1'b0;
            eof <= 1'b0;
            busy_o <= 1'b0;
            state <= IDLE;
          end else begin
            valid <= 1'b0;
            led_idx <= led_idx + 1'b1;
            ch <= CH_G;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ws2812b_frame_streamer.sv
// tb_ws2812b_frame_streamer: scoreboard bench for the frame streamer plus an auto-launch instance
module tb_ws2812b_frame_streamer;
  import ws2812b_pkg::*;
  localparam int N = 40;
  localparam int IW = idx_w(N);
  localparam int NB = BYTES_PER_LED * N;
  localparam int AP = 20;
  typedef struct packed { logic [7:0] b; logic sof; logic eof; } exp_t;
  typedef struct { logic [23:0] rgb; logic [7:0] br, g, r, b; } tv_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic wr_en_i = 1'b0;
  logic [IW-1:0] wr_addr_i = '0;
  logic [23:0] wr_rgb_i = '0;
  logic swap_req_i = 1'b0;
  logic frame_req_i = 1'b0;
  logic [7:0] bright_i = 8'hFF;
  logic busy_o, swap_done_o, a_busy, a_swap_done;
  ws2812b_frame_streamer_if bs();
  ws2812b_frame_streamer_if as();
  always #5 clk_i = ~clk_i;
  ws2812b_frame_streamer #(.NUM_LED(N), .FRAME_PERIOD(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_rgb_i(wr_rgb_i),
    .swap_req_i(swap_req_i), .frame_req_i(frame_req_i), .bright_i(bright_i),
    .strm(bs.master), .busy_o(busy_o), .swap_done_o(swap_done_o)
  );
  ws2812b_frame_streamer #(.NUM_LED(2), .FRAME_PERIOD(AP)) dut_auto (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(1'b0), .wr_addr_i(1'b0), .wr_rgb_i(24'h0),
    .swap_req_i(1'b0), .frame_req_i(1'b0), .bright_i(8'hFF),
    .strm(as.master), .busy_o(a_busy), .swap_done_o(a_swap_done)
  );
  exp_t q[$];
  exp_t mon_e;
  logic [23:0] mb [2][N];
  logic fm = 1'b0;
  logic [7:0] cap [NB];
  logic [7:0] f1e [6];
  tv_t tv [7];
  int errs = 0, checks = 0, cyc = 0, frames = 0, bif = 0, sd_cnt = 0, eof_cyc = -1000, last_gap = 0;
  int sd0, f0, s1, s2;
  logic [7:0] old_g;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [7:0] sc(logic [7:0] c, logic [7:0] b);
    int p;
    p = int'(c) * (int'(b) + 1);
    return 8'(p / 256);
  endfunction
  always @(negedge clk_i)
    if (!rst_i) begin
      if (swap_done_o) sd_cnt++;
      if (bs.byte_valid_o && bs.byte_ready_i) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_byte: got 0x%0h, want no byte (cycle %0d)", bs.byte_o, cyc);
        end else begin
          mon_e = q.pop_front();
          check("byte", bs.byte_o, mon_e.b);
          check("sof", bs.sof_o, mon_e.sof);
          check("eof", bs.eof_o, mon_e.eof);
        end
        if (bs.sof_o) begin
          bif = 0;
          frames++;
          last_gap = cyc - eof_cyc;
        end
        if (bif < NB) cap[bif] = bs.byte_o;
        bif++;
        if (bs.eof_o) begin
          check("frame_len", bif, NB);
          eof_cyc = cyc;
        end
      end
    end
  task automatic push_frame(logic [7:0] br);
    for (int i = 0; i < N; i++) begin
      q.push_back('{b: sc(mb[fm][i][15:8], br), sof: i == 0, eof: 1'b0});
      q.push_back('{b: sc(mb[fm][i][23:16], br), sof: 1'b0, eof: 1'b0});
      q.push_back('{b: sc(mb[fm][i][7:0], br), sof: 1'b0, eof: i == N - 1});
    end
  endtask
  task automatic wr(int idx, logic [23:0] rgb);
    wr_en_i = 1'b1;
    wr_addr_i = IW'(idx);
    wr_rgb_i = rgb;
    if (idx < N) mb[!fm][idx] = rgb;
    @(posedge clk_i);
    #1 wr_en_i = 1'b0;
  endtask
  task automatic launch(logic sw);
    if (sw) fm = !fm;
    push_frame(bright_i);
    swap_req_i = sw;
    frame_req_i = 1'b1;
    @(posedge clk_i);
    #1 swap_req_i = 1'b0;
    frame_req_i = 1'b0;
  endtask
  task automatic wait_done(string nm);
    int t = 0;
    while ((busy_o || q.size() != 0) && t < 5000) begin
      @(posedge clk_i);
      #1 t++;
    end
    check({"done_", nm}, t < 5000, 1);
  endtask
  task automatic wait_q(int n);
    int t = 0;
    while (q.size() > n && t < 2000) begin
      @(posedge clk_i);
      #1 t++;
    end
    check("wait_q", t < 2000, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv[0] = '{24'hFF8001, 8'd127, 8'h40, 8'h7F, 8'h00};
    tv[1] = '{24'hFF8001, 8'd0, 8'h00, 8'h00, 8'h00};
    tv[2] = '{24'h112233, 8'd255, 8'h22, 8'h11, 8'h33};
    tv[3] = '{24'hFFFFFF, 8'd255, 8'hFF, 8'hFF, 8'hFF};
    tv[4] = '{24'hFFFFFF, 8'd1, 8'h01, 8'h01, 8'h01};
    tv[5] = '{24'h406080, 8'd63, 8'h18, 8'h10, 8'h20};
    tv[6] = '{24'h00FF00, 8'd254, 8'hFE, 8'h00, 8'h00};
    f1e = '{8'h22, 8'h11, 8'h33, 8'hBB, 8'hAA, 8'hCC};
    bs.byte_ready_i = 1'b1;
    as.byte_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", bs.byte_valid_o, 0);
    check("rst_sof", bs.sof_o, 0);
    check("rst_eof", bs.eof_o, 0);
    check("rst_byte", bs.byte_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_swap_done", swap_done_o, 0);
    rst_i = 1'b0;
    s1 = -1;
    s2 = -1;
    for (int t = 0; t < 5 * AP && s2 < 0; t++) begin
      @(negedge clk_i);
      if (as.byte_valid_o && as.sof_o) begin
        if (s1 < 0) s1 = cyc;
        else s2 = cyc;
      end
    end
    check("auto_period", s2 - s1, AP);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < N; i++)
      wr(i, i == 0 ? 24'h112233 : i == 1 ? 24'hAABBCC : 24'(i * 24'h030507 + 24'h102030));
    sd0 = sd_cnt;
    launch(1'b1);
    wait_done("first");
    check("first_swap_done", sd_cnt - sd0, 1);
    for (int i = 0; i < 6; i++) check("first_bytes", cap[i], f1e[i]);
    for (int i = 0; i < N; i++) wr(i, 24'(i * 24'h0B0D11) ^ 24'h5A5A5A);
    wr(63, 24'hDEAD00);
    bs.byte_ready_i = 1'b0;
    sd0 = sd_cnt;
    launch(1'b0);
    for (int t = 0; t < 20 && !bs.byte_valid_o; t++) begin
      @(posedge clk_i);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("bp_valid", bs.byte_valid_o, 1);
      check("bp_byte", bs.byte_o, 8'h22);
      check("bp_sof", bs.sof_o, 1);
    end
    @(posedge clk_i);
    #1 bs.byte_ready_i = 1'b1;
    wait_done("bp");
    check("bp_no_swap", sd_cnt - sd0, 0);
    launch(1'b0);
    for (int t = 0; t < 3000 && q.size() != 0; t++) begin
      bs.byte_ready_i = $urandom_range(0, 3) != 0;
      @(posedge clk_i);
      #1;
    end
    bs.byte_ready_i = 1'b1;
    wait_done("rand_bp");
    for (int k = 0; k < 7; k++) begin
      bright_i = tv[k].br;
      wr(0, tv[k].rgb);
      launch(1'b1);
      wait_done("tv");
      check("tv_g", cap[0], tv[k].g);
      check("tv_r", cap[1], tv[k].r);
      check("tv_b", cap[2], tv[k].b);
    end
    bright_i = 8'hFF;
    f0 = frames;
    launch(1'b0);
    wait_q(NB - 10);
    for (int j = 0; j < 3; j++) begin
      frame_req_i = 1'b1;
      @(posedge clk_i);
      #1 frame_req_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
    end
    push_frame(bright_i);
    wait_done("collapse");
    repeat (30) @(posedge clk_i);
    #1;
    check("collapse_frames", frames - f0, 2);
    check("collapse_gap", last_gap, 3);
    check("collapse_idle", busy_o, 0);
    launch(1'b0);
    wait_q(NB - 6);
    wr(5, 24'h00FF00);
    frame_req_i = 1'b1;
    push_frame(bright_i);
    @(posedge clk_i);
    #1 frame_req_i = 1'b0;
    wait_done("iso_old");
    old_g = mb[fm][5][15:8];
    check("iso_old_g", cap[15], old_g);
    launch(1'b1);
    wait_done("iso_new");
    check("iso_new_g", cap[15], 8'hFF);
    launch(1'b0);
    wait_q(NB - 100);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("mid_rst_valid", bs.byte_valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    q.delete();
    fm = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    f0 = frames;
    launch(1'b0);
    wait_done("after_rst");
    check("after_rst_frames", frames - f0, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
